// File: rtl/frame_scanout.sv
`timescale 1ns/1ps
// Double-buffered 320x240x3 frame store with 640x480@60 VGA scanout and 2x2 pixel replication.
// Pixel writes land in the back bank; banks swap only at the start of vertical blanking.
module frame_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       swap_req,
    output logic       swap_done,
    output logic       front,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_clk
);
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_VIS + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_VIS + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;
    localparam int NPIX   = 320 * 240;

    logic       pix_en_q, pix_en_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       front_q, front_d;
    logic       pending_q, pending_d;
    logic       swap_done_q, swap_done_d;
    logic       line_end, swap_tick, swap_fire;

    always_comb begin
        pix_en_d    = ~pix_en_q;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        line_end    = pix_en_q && (hcount_q == 10'(H_TOT - 1));
        swap_tick   = line_end && (vcount_q == 10'(V_VIS - 1));
        swap_fire   = swap_tick && pending_q;
        if (pix_en_q) begin
            if (line_end) begin
                hcount_d = '0;
                vcount_d = (vcount_q == 10'(V_TOT - 1)) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
        front_d     = swap_fire ? ~front_q : front_q;
        // A request coinciding with the firing swap is absorbed by it.
        pending_d   = swap_fire ? 1'b0 : (pending_q | swap_req);
        swap_done_d = swap_fire;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en_q    <= 1'b0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            pix_en_q    <= pix_en_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            front_q     <= front_d;
            pending_q   <= pending_d;
            swap_done_q <= swap_done_d;
        end
    end

    logic        wr_en;
    logic [16:0] wr_addr, rd_addr;
    logic [8:0]  rd_x;
    logic [7:0]  rd_y;
    logic        vis_c, hs_c, vs_c;

    assign wr_en   = plot && (x < 9'd320) && (y < 8'd240);
    assign wr_addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
    assign rd_x    = hcount_q[9:1];
    assign rd_y    = vcount_q[8:1];
    assign rd_addr = {1'b0, rd_y, 8'b0} + {3'b0, rd_y, 6'b0} + {8'b0, rd_x};
    assign vis_c   = (hcount_q < 10'(H_VIS)) && (vcount_q < 10'(V_VIS));
    assign hs_c    = !((hcount_q >= 10'(HS_BEG)) && (hcount_q < 10'(HS_END)));
    assign vs_c    = !((vcount_q >= 10'(VS_BEG)) && (vcount_q < 10'(VS_END)));

    logic [2:0] rd_data [2];

    // Reads are only enabled in the visible area, which keeps rd_addr inside the bank.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_bank
            logic [2:0] mem [NPIX];
            logic [2:0] rd_q;
            always_ff @(posedge clk) begin
                if (wr_en && (front_q != 1'(gi)))
                    mem[wr_addr] <= colour;
                if (vis_c)
                    rd_q <= mem[rd_addr];
            end
            assign rd_data[gi] = rd_q;
        end
    endgenerate

    logic       hs1_q, vs1_q, vis1_q, front1_q;
    logic       hs2_q, vs2_q, vis2_q;
    logic [7:0] r_q, g_q, b_q;
    logic [2:0] pix_c;

    assign pix_c = front1_q ? rd_data[1] : rd_data[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            vis1_q   <= 1'b0;
            front1_q <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            vis2_q   <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            hs1_q    <= hs_c;
            vs1_q    <= vs_c;
            vis1_q   <= vis_c;
            front1_q <= front_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            vis2_q   <= vis1_q;
            r_q      <= {8{vis1_q & pix_c[2]}};
            g_q      <= {8{vis1_q & pix_c[1]}};
            b_q      <= {8{vis1_q & pix_c[0]}};
        end
    end

    assign swap_done   = swap_done_q;
    assign front       = front_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign vga_blank_n = vis2_q;
    assign vga_clk     = pix_en_q;
endmodule

// File: tb/tb_frame_scanout.sv
`timescale 1ns/1ps
// Scoreboard bench for frame_scanout on a shrunken 16x8 raster (24x12 total) so whole frames fit in a short run.
module tb_frame_scanout;
    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = 2 * H_TOT * V_TOT;
    localparam int SWAP_OFS = 2 * H_TOT * V_VIS;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] x = '0;
    logic [7:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       swap_req = 1'b0;
    logic       swap_done, front, vga_hs, vga_vs, vga_blank_n, vga_clk;
    logic [7:0] vga_r, vga_g, vga_b;

    always #10 clk = ~clk;

    frame_scanout #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
        .swap_req(swap_req), .swap_done(swap_done), .front(front),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
    );

    // p = number of clock edges since the last reset release
    int p;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) p <= 0;
        else         p <= p + 1;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic        f_m      = 1'b0;
    logic [2:0]  bank_m [2][4][8];
    logic [24:0] pix_q [$];
    logic        swap_q [$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (p=%0d)", name, act, exp, p);
        end
    endfunction

    task automatic at(input int k);
        while (p < k - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int k, input int wx, input int wy, input logic [2:0] c);
        at(k);
        x = 9'(wx); y = 8'(wy); colour = c; plot = 1'b1;
        if (wx < 8 && wy < 4) bank_m[f_m ? 0 : 1][wy][wx] = c;
        $display("write p=%0d x=%0d y=%0d colour=%b back=%0d", k, wx, wy, c, !f_m);
        @(posedge clk);
        #1;
        plot = 1'b0;
    endtask

    task automatic req(input int k);
        at(k);
        swap_req = 1'b1;
        $display("swap_req p=%0d", k);
        @(posedge clk);
        #1;
        swap_req = 1'b0;
    endtask

    task automatic swap_at(input int k);
        at(k + 1);
        f_m = !f_m;
    endtask

    task automatic push_frame();
        logic [2:0]  c;
        logic [24:0] e;
        for (int v = 0; v < V_VIS; v++) begin
            for (int h = 0; h < H_VIS; h++) begin
                c = bank_m[f_m ? 1 : 0][v >> 1][h >> 1];
                e = {f_m, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
                pix_q.push_back(e);
                pix_q.push_back(e);
            end
        end
        $display("frame queued p=%0d front=%0d", p, f_m);
    endtask

    // Monitor: pops pixel/swap expectations and checks raster geometry.
    initial begin : monitor
        logic [24:0] e;
        logic        ef;
        logic        hs_prev = 1'b1, vs_prev = 1'b1, bl_prev = 1'b0;
        int          hs_fall = -1, vs_fall = -1, bl_start = 0, bl_lines = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (vga_blank_n) begin
                    if (pix_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL pixel_underflow: got visible pixel at p=%0d, expected none", p);
                    end else begin
                        e = pix_q.pop_front();
                        check("pixel", {7'b0, front, vga_r, vga_g, vga_b}, {7'b0, e});
                    end
                end
                if (swap_done) begin
                    $display("swap_done p=%0d front=%0d", p, front);
                    if (swap_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_swap: got swap_done at p=%0d, expected none", p);
                    end else begin
                        ef = swap_q.pop_front();
                        check("swap_front", {31'b0, front}, {31'b0, ef});
                        check("swap_phase", p % FRAME, SWAP_OFS);
                    end
                end
                if (hs_prev && !vga_hs) begin
                    if (hs_fall < 0) check("hs_first_fall", p, 2 * (H_VIS + H_FP) + 2);
                    else             check("hs_period", p - hs_fall, 2 * H_TOT);
                    hs_fall = p;
                end
                if (!hs_prev && vga_hs) check("hs_low_len", p - hs_fall, 2 * H_SYNC);
                if (vs_prev && !vga_vs) begin
                    if (vs_fall < 0) check("vs_first_fall", p, 2 * H_TOT * (V_VIS + V_FP) + 2);
                    else             check("vs_period", p - vs_fall, FRAME);
                    check("lines_per_frame", bl_lines, V_VIS);
                    bl_lines = 0;
                    vs_fall = p;
                end
                if (!vs_prev && vga_vs) check("vs_low_len", p - vs_fall, 2 * H_TOT * V_SYNC);
                if (!bl_prev && vga_blank_n) bl_start = p;
                if (bl_prev && !vga_blank_n) begin
                    check("blank_len", p - bl_start, 2 * H_VIS);
                    bl_lines++;
                end
                hs_prev = vga_hs;
                vs_prev = vga_vs;
                bl_prev = vga_blank_n;
            end
        end
    end

    initial begin : stimulus
        // Phase A: clear the displayed region of both banks, then reset mid-frame.
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        for (int i = 0; i < 32; i++) wr(2 + i, i % 8, i / 8, 3'b000);
        req(40);
        swap_at(SWAP_OFS);
        for (int i = 0; i < 32; i++) wr(400 + i, i % 8, i / 8, 3'b000);
        at(700);
        check("front_before_reset", {31'b0, front}, 32'd1);
        resetn = 1'b0;
        #2;
        check("rst_hs", {31'b0, vga_hs}, 32'd1);
        check("rst_vs", {31'b0, vga_vs}, 32'd1);
        check("rst_blank_n", {31'b0, vga_blank_n}, 32'd0);
        check("rst_rgb", {8'b0, vga_r, vga_g, vga_b}, 32'd0);
        check("rst_front", {31'b0, front}, 32'd0);
        check("rst_swap_done", {31'b0, swap_done}, 32'd0);
        check("rst_vga_clk", {31'b0, vga_clk}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_held_front", {31'b0, front}, 32'd0);
        f_m = 1'b0;
        push_frame();
        #2;
        resetn = 1'b1;
        mon_en = 1'b1;
        $display("reset released");

        // Frame 0: draw into bank 1, two rejected writes, three merged requests.
        wr(10, 5, 3, 3'b101);
        wr(11, 7, 0, 3'b010);
        wr(12, 0, 2, 3'b110);
        wr(13, 320, 0, 3'b111);
        wr(14, 0, 240, 3'b111);
        req(60);
        req(250);
        req(254);
        swap_q.push_back(1'b1);
        swap_at(SWAP_OFS);

        // Frame 1: bank 1 shown; write bank 0; request plus write on the swap cycle itself.
        at(FRAME);
        push_frame();
        wr(600, 2, 1, 3'b011);
        req(700);
        swap_q.push_back(1'b0);
        at(FRAME + SWAP_OFS);
        swap_req = 1'b1; plot = 1'b1; x = 9'd3; y = 8'd2; colour = 3'b100;
        bank_m[f_m ? 0 : 1][2][3] = 3'b100;
        $display("swap_req+write on swap cycle p=%0d x=3 y=2 colour=100", FRAME + SWAP_OFS);
        @(posedge clk);
        #1;
        swap_req = 1'b0; plot = 1'b0;
        f_m = !f_m;

        // Frame 2: no swap expected; frame 3 swaps back to bank 1 for a second look.
        at(2 * FRAME);
        push_frame();
        at(3 * FRAME);
        push_frame();
        req(3 * FRAME + 100);
        swap_q.push_back(1'b1);
        swap_at(3 * FRAME + SWAP_OFS);
        at(4 * FRAME);
        push_frame();
        at(5 * FRAME - 10);
        mon_en = 1'b0;
        check("pix_queue_drained", pix_q.size(), 0);
        check("swap_queue_drained", swap_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_scanout.md
# frame_scanout

Double-buffered 320x240, 3-bit-colour frame store with VGA 640x480@60 scanout. It sits downstream of the sprite and erase pixel generators: it accepts their per-cycle pixel writes (x, y, colour, plot) into the back bank. At the same time it scans the front bank out to the DAC with 2x2 pixel replication. Bank swaps happen only at the start of vertical blanking, so a frame is never shown half-drawn.

## Interface
- Parameters:
- H_VIS, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks
- V_VIS, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  asynchronous, active-low reset
- x  in  9  write column, 0..319
- y  in  8  write row, 0..239
- colour  in  3  write colour; bit2=R, bit1=G, bit0=B
- plot  in  1  write strobe; one pixel is written per cycle while high
- swap_req  in  1  single-cycle request to swap banks at the next vblank
- swap_done  out  1  single-cycle pulse on the cycle the swap takes effect
- front  out  1  index of the bank currently displayed
- vga_r / vga_g / vga_b  out  8 each  colour outputs
- vga_hs / vga_vs  out  1 each  syncs, active low
- vga_blank_n  out  1  high during the visible area
- vga_clk  out  1  pixel clock, equal to the pix_en phase (25 MHz)

## Operation
- Storage: two banks of 76800 x 3 bits each, implemented as inferred RAM with one write port and one synchronous read port. Contents are not reset.
- Address = y*320 + x, computed as (y<<8)+(y<<6)+x and 17 bits wide.
- Writes:
  - Writes go to the back bank, which is always ~front.
  - A write with x>319 or y>239 is dropped.
  - There is no backpressure.
  - A write issued in the same cycle a swap takes effect goes to the pre-swap back bank.
- Timing generator:
  - pix_en toggles every clk and is 0 in the first cycle after reset.
  - hcount (0..799) and vcount (0..524) advance only on cycles where pix_en=1.
  - hcount wraps 799->0 and increments vcount at that point; vcount wraps 524->0.
- Sync and blank:
  - hs is low for hcount in 656..751.
  - vs is low for vcount in 490..491.
  - The visible area is hcount<640 and vcount<480.
- Read: address = (vcount>>1)*320 + (hcount>>1) into the front bank.
- Colour output:
  - Each 3-bit colour bit expands to 8'hFF or 8'h00 on its channel.
  - All three channels are forced to 0 outside the visible area.
- Swap:
  - swap_req sets a pending flag. Repeated requests while pending merge into one swap.
  - The swap fires on the pix_en tick where vcount goes 479->480. On that tick, front toggles, pending clears and swap_done pulses for one clk.
  - A swap_req arriving on that exact cycle is absorbed by that swap; it does not re-arm pending.
- Reset (async, when resetn low):
  - Counters are set to 0, front=0, pending=0, swap_done=0.
  - vga_hs=vga_vs=1, vga_blank_n=0, RGB=0, vga_clk=0.
  - Reset mid-frame restarts the scan at (0,0) from the next pix_en tick.

## Timing
- Write latency: a pixel written on cycle n is readable by scanout from cycle n+1.
- Scanout pipeline: counters -> registered RAM read -> registered outputs, 2 clk total.
  - vga_hs, vga_vs and vga_blank_n are delayed by the same 2 clk, so all VGA outputs are mutually aligned.
- Line period: 1600 clk. Frame period: 840000 clk (59.52 Hz at 50 MHz).
- swap_done precedes the first visible pixel of the next frame by 45 lines.
- The front output changes in the same cycle as swap_done.

## Test plan
- Reset check: hold resetn low mid-frame, then release.
  - During reset: hs=vs=1, blank_n=0, RGB=0, front=0.
  - After release: the first hs low edge appears at hcount 656, i.e. about 1312+2 clk after release.
- Write and display, single pixel:
  - With front=0, write x=5, y=3, colour=3'b101 to bank 1, then swap.
  - Next frame: on lines 6..7 at columns 10..11, R=FF, G=00, B=FF.
  - Every other visible pixel shows the bank 1 initial content, which is preloaded to 0.
- Out-of-range write: write x=320, y=0 and x=0, y=240.
  - No bank location changes; verify by scanning both banks after swaps.
- Swap timing: pulse swap_req at vcount=100, then pulse it twice more at vcount=200.
  - Exactly one swap_done at the vcount 479->480 tick; front flips once.
  - No swap occurs in the following frame.
- Simultaneous events: pulse swap_req and plot on the exact swap cycle.
  - The write lands in the pre-swap back bank, i.e. the bank now displayed.
  - No second swap occurs the next frame.
- Sync geometry over 2 frames:
  - hs low for 192 clk every 1600 clk.
  - vs low for 3200 clk every 840000 clk.
  - blank_n high for 1280 clk on each of 480 lines.
